// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, valid/ready byte output, framing and overrun flags
module uart_rx #(
    parameter int CLK_FREQ      = 48_000_000,
    parameter int UART_CLK_FREQ = 115_200,
    parameter bit RX_INVERT     = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UART_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       RX_FRAME_ERR,
    output logic       RX_OVERRUN,
    output logic       RX_BUSY
);
    localparam int CYCLES_PER_BIT = CLK_FREQ / UART_CLK_FREQ;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    generate
        if (CYCLES_PER_BIT < 4) begin : g_baud_check
            $error("uart_rx: CLK_FREQ / UART_CLK_FREQ must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_s;

    assign rx_s = rx_sync ^ RX_INVERT;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            state        <= S_IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            RX_DATA      <= 8'h00;
            RX_VALID     <= 1'b0;
            RX_FRAME_ERR <= 1'b0;
            RX_OVERRUN   <= 1'b0;
            RX_BUSY      <= 1'b0;
        end else begin
            rx_meta      <= UART_RX;
            rx_sync      <= rx_meta;
            RX_FRAME_ERR <= 1'b0;
            RX_OVERRUN   <= 1'b0;
            // A consumed byte drops valid; a delivery in the same cycle re-raises it below.
            if (RX_VALID && RX_READY) begin
                RX_VALID <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state   <= S_START;
                        RX_BUSY <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        idx <= '0;
                        if (!rx_s) begin
                            state <= S_DATA;
                        end else begin
                            state   <= S_IDLE;
                            RX_BUSY <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state   <= S_IDLE;
                            RX_BUSY <= 1'b0;
                            if (!RX_VALID || RX_READY) begin
                                RX_DATA  <= shreg;
                                RX_VALID <= 1'b1;
                            end else begin
                                RX_OVERRUN <= 1'b1;
                            end
                        end else begin
                            state        <= S_BREAK;
                            RX_FRAME_ERR <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_BREAK: begin
                    // Held-low line reports one framing error, then waits for idle.
                    cnt <= '0;
                    if (rx_s) begin
                        state   <= S_IDLE;
                        RX_BUSY <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    RX_BUSY <= 1'b0;
                end
            endcase
        end
    end
endmodule
